dac_ramp_analyzer: RTL
======================

Name: dac_ramp_analyzer

Overview:
- Receive-side counterpart of the DAC ramp stimulus: checks a resistor-ladder DAC channel sweeping codes 0..2^CODE_BITS-1 while an external ADC digitises its analog output.
- Consumes paired (DAC code, ADC sample) beats, discards settling samples, and averages a fixed number of samples per code.
- Emits one result per code: averaged level, step from the previous code, and an error flag. Errors cover non-monotonic or too-small steps, too-short dwell, and code-sequence breaks.
- Sits beside the RGB/YPbPr DAC outputs as a bring-up and linearity checker.

Parameters:
CODE_BITS, 4, DAC code width; a sweep is 2^CODE_BITS codes
ADC_BITS, 8, ADC sample width
SETTLE, 2, valid samples discarded after each code change (0..15)
AVG_LOG2, 2, log2 of samples averaged per code (0..4)
MIN_STEP, 1, minimum required level increase per code (ADC LSB)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse: arm a new sweep (ignored unless IDLE or DONE)
smp_valid  in  1  sample beat valid
smp_data  in  ADC_BITS  ADC sample, unsigned
smp_code  in  CODE_BITS  DAC code applied when smp_data was taken
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid and res_ready are both high
res_code  out  CODE_BITS  code the result belongs to
res_level  out  ADC_BITS  averaged level
res_step  out  ADC_BITS+1  signed res_level minus previous level; 0 for code 0
res_err  out  1  step < MIN_STEP (code > 0), or short dwell
busy  out  1  sweep in progress
done  out  1  sweep finished; held until start or rst
seq_err  out  1  sticky: code sequence broken, sweep aborted
ovf  out  1  sticky: result dropped because res_valid was held
err_count  out  CODE_BITS+1  number of results with res_err set in this sweep

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, accumulator 0, previous level 0.
- start clears done, seq_err, ovf, err_count and the accumulator, then enters WAIT0. start while busy is ignored.
- Only beats with smp_valid=1 advance the FSM. With smp_valid=0 the FSM holds its state.
- WAIT0: wait for a beat with smp_code=0. On that beat, cur_code=0 and the beat counts as settle sample 1, then go to SETTLE (ACC directly if SETTLE=0).
- SETTLE: discard beats until SETTLE beats of cur_code have been seen, then go to ACC.
- ACC: sum += smp_data, using a sum width of ADC_BITS+AVG_LOG2 (no overflow possible). After 2^AVG_LOG2 beats go to HOLD.
  - level = sum >> AVG_LOG2, truncated.
  - The result is registered on the clock edge after the last accumulated beat.
- HOLD: ignore beats while smp_code==cur_code.
- Code change, detected in any of SETTLE, ACC or HOLD:
  - smp_code == cur_code+1: accept. If the change arrives before ACC completes, emit cur_code with the partial-sum level, flagged short (res_err=1). Then cur_code++ and count the changing beat as settle sample 1.
  - The same beat both finishing ACC and carrying a new code cannot occur, because a code change preempts accumulation.
  - Any other code, including wrap before the maximum code: set seq_err, busy=0, done=1, discard the partial result, go to DONE.
- Result:
  - res_step = level - prev_level. prev_level updates on every emitted result.
  - res_err = short OR (cur_code>0 AND res_step < MIN_STEP, compared signed). err_count increments when res_err is set.
- Output register is single-entry:
  - res_valid stays high until the handshake completes; all res_* fields are stable while res_valid is high.
  - If a new result is produced while res_valid=1 and res_ready=0, the new result is dropped, ovf is set, and prev_level still updates.
  - A handshake and a new result in the same cycle: load the new result, res_valid stays 1.
- Sweep end: after the result for code 2^CODE_BITS-1 is loaded, go to DONE. busy falls and done rises on the same edge. The final result is still delivered via handshake.
- busy is 1 in WAIT0, SETTLE, ACC and HOLD.
- Reset mid-sweep: immediate return to the reset state, and any pending result is lost.

Decomposition:
- Shared package dac_test_pkg holds:
  - state enum (IDLE, WAIT0, SETTLE, ACC, HOLD, DONE)
  - default widths CODE_BITS=4, ADC_BITS=8
- One natural sub-module, dac_step_acc: settle counter, sample counter, accumulator, and the level/step/err computation.
- The top-level keeps the FSM, sequence check, output register and sticky flags.

Test Plan:
1. Ideal ramp: code k, sample 16k, 8 beats per code, res_ready=1 -> 16 results with level 16k, step 16 (0 for code 0), res_err=0, err_count=0, done=1, seq_err=0.
2. Averaging/settle: code 0 beats 255,255,10,11,12,13 -> level 11 (46>>2); the 255s are discarded.
3. Non-monotonic: code 7 samples 90, code 6 level 96 -> code 7 step -6, err=1; code 8 (128) step 38, err=0; final err_count=1.
4. Short dwell: code 5 lasts 4 beats (2 settle + 2 acc of 80) -> code 5 level 40, err=1; code 6 measured normally.
5. Sequence break: code 3 followed by 5 -> seq_err=1, done=1, busy=0, no result for code 3. A later start clears seq_err.
6. Backpressure/reset: res_ready=0 across two results -> first held stable, ovf=1. Then assert rst mid-ACC -> all outputs 0 on the next sample point; start re-runs scenario 1 cleanly.

Source files
------------

// File: rtl/dac_test_pkg.sv
// rtl/dac_test_pkg.sv - shared state encoding and default widths for the DAC ramp checker
package dac_test_pkg;

  localparam int DEF_CODE_BITS = 4;
  localparam int DEF_ADC_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT0  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACC    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/dac_step_acc.sv
// rtl/dac_step_acc.sv - per-code settle/sample counting, averaging and step/error evaluation
module dac_step_acc
  import dac_test_pkg::*;
#(
  parameter int ADC_BITS = DEF_ADC_BITS,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2,
  parameter int MIN_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                restart,
  input  logic                settle_inc,
  input  logic                acc_en,
  input  logic                commit,
  input  logic                short_res,
  input  logic                code_zero,
  input  logic [ADC_BITS-1:0] data,
  output logic                settle_last,
  output logic                acc_last,
  output logic [ADC_BITS-1:0] level,
  output logic [ADC_BITS:0]   step,
  output logic                err
);

  localparam int SUM_W = ADC_BITS + AVG_LOG2;
  localparam logic [AVG_LOG2:0] ACC_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic signed [ADC_BITS:0] MIN_S = (ADC_BITS + 1)'(MIN_STEP);

  logic [3:0]          settle_cnt;
  logic [AVG_LOG2:0]   acc_cnt;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [SUM_W-1:0]    lvl_src;
  logic [ADC_BITS-1:0] prev_level;
  logic [ADC_BITS:0]   diff;

  assign sum_next    = sum + SUM_W'(data);
  assign settle_last = ({1'b0, settle_cnt} + 5'd1) >= 5'(SETTLE);
  assign acc_last    = acc_cnt == ACC_LAST;

  // A short dwell reports the partial sum; a full one includes the beat being accumulated now.
  assign lvl_src = short_res ? sum : sum_next;
  assign level   = lvl_src[SUM_W-1:AVG_LOG2];
  assign diff    = {1'b0, level} - {1'b0, prev_level};
  assign step    = code_zero ? '0 : diff;
  assign err     = short_res || (!code_zero && ($signed(step) < MIN_S));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      acc_cnt    <= '0;
      sum        <= '0;
      prev_level <= '0;
    end else if (clr) begin
      settle_cnt <= '0;
      acc_cnt    <= '0;
      sum        <= '0;
      prev_level <= '0;
    end else begin
      if (restart) begin
        settle_cnt <= 4'd1;
        acc_cnt    <= '0;
        sum        <= '0;
      end else if (settle_inc) begin
        settle_cnt <= settle_cnt + 4'd1;
      end else if (acc_en) begin
        sum     <= sum_next;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (commit) prev_level <= level;
    end
  end

endmodule

// File: rtl/dac_ramp_analyzer.sv
// rtl/dac_ramp_analyzer.sv - sweep FSM, code sequence check, single-entry result register and sticky flags
module dac_ramp_analyzer
  import dac_test_pkg::*;
#(
  parameter int CODE_BITS = DEF_CODE_BITS,
  parameter int ADC_BITS  = DEF_ADC_BITS,
  parameter int SETTLE    = 2,
  parameter int AVG_LOG2  = 2,
  parameter int MIN_STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 smp_valid,
  input  logic [ADC_BITS-1:0]  smp_data,
  input  logic [CODE_BITS-1:0] smp_code,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CODE_BITS-1:0] res_code,
  output logic [ADC_BITS-1:0]  res_level,
  output logic [ADC_BITS:0]    res_step,
  output logic                 res_err,
  output logic                 busy,
  output logic                 done,
  output logic                 seq_err,
  output logic                 ovf,
  output logic [CODE_BITS:0]   err_count
);

  localparam logic [CODE_BITS-1:0] MAX_CODE = '1;
  localparam state_t AFTER_CHANGE = (SETTLE <= 1) ? ST_ACC : ST_SETTLE;

  state_t               state;
  logic [CODE_BITS-1:0] cur_code;
  logic                 same_code, next_code, in_meas;
  logic                 emit_full, emit_short, emit, restart, clr;
  logic                 settle_last, acc_last, step_err;
  logic [ADC_BITS-1:0]  level;
  logic [ADC_BITS:0]    step;

  assign same_code  = smp_code == cur_code;
  assign next_code  = {1'b0, smp_code} == ({1'b0, cur_code} + 1'b1);
  assign in_meas    = state inside {ST_SETTLE, ST_ACC, ST_HOLD};
  assign emit_full  = smp_valid && state == ST_ACC && same_code && acc_last;
  assign emit_short = smp_valid && (state == ST_SETTLE || state == ST_ACC) && !same_code && next_code;
  assign emit       = emit_full || emit_short;
  assign restart    = smp_valid && ((state == ST_WAIT0 && smp_code == '0) ||
                                    (in_meas && !same_code && next_code));
  assign clr        = start && (state == ST_IDLE || state == ST_DONE);

  dac_step_acc #(
    .ADC_BITS (ADC_BITS),
    .SETTLE   (SETTLE),
    .AVG_LOG2 (AVG_LOG2),
    .MIN_STEP (MIN_STEP)
  ) u_step_acc (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .restart     (restart),
    .settle_inc  (smp_valid && state == ST_SETTLE && same_code),
    .acc_en      (smp_valid && state == ST_ACC && same_code),
    .commit      (emit),
    .short_res   (emit_short),
    .code_zero   (cur_code == '0),
    .data        (smp_data),
    .settle_last (settle_last),
    .acc_last    (acc_last),
    .level       (level),
    .step        (step),
    .err         (step_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_code  <= '0;
      res_valid <= 1'b0;
      res_code  <= '0;
      res_level <= '0;
      res_step  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
      ovf       <= 1'b0;
      err_count <= '0;
    end else begin
      // A held, unconsumed result wins; the new one is dropped but still counted.
      if (emit) begin
        if (res_valid && !res_ready) begin
          ovf <= 1'b1;
        end else begin
          res_valid <= 1'b1;
          res_code  <= cur_code;
          res_level <= level;
          res_step  <= step;
          res_err   <= step_err;
        end
        if (step_err) err_count <= err_count + 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_WAIT0;
            busy      <= 1'b1;
            done      <= 1'b0;
            seq_err   <= 1'b0;
            ovf       <= 1'b0;
            err_count <= '0;
          end
        end
        ST_WAIT0: begin
          if (restart) begin
            cur_code <= '0;
            state    <= AFTER_CHANGE;
          end
        end
        ST_SETTLE, ST_ACC, ST_HOLD: begin
          if (smp_valid) begin
            if (same_code) begin
              if (state == ST_SETTLE && settle_last) begin
                state <= ST_ACC;
              end else if (emit_full) begin
                if (cur_code == MAX_CODE) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= ST_HOLD;
                end
              end
            end else if (next_code) begin
              cur_code <= smp_code;
              state    <= AFTER_CHANGE;
            end else begin
              seq_err <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
